// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte producers.
// Optional LINE_LOCK_EN: holds the grant on one requester until it sends 0x0A or goes idle.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ACK_TIMEOUT  = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 err,
    output logic                 tx_we,
    output logic [7:0]           tx_din,
    input  logic                 tx_empty
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [AW-1:0]      ack_q, ack_d;
    logic [NUM_REQ-1:0] ready_d, grant_d;
    logic               busy_d, err_d, we_d;
    logic [7:0]         din_d;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [IW-1:0]      sel;

`ifdef LINE_LOCK_EN
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    logic          lock_q, lock_d;
    logic [IW-1:0] lidx_q, lidx_d;
    logic [LW-1:0] lcnt_q, lcnt_d;

    assign elig = lock_q ? (req_valid & (ONE << lidx_q)) : req_valid;
`else
    assign elig = req_valid;
`endif

    // First eligible index searching upward from rr_q, wrapping.
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && elig[IW'(j)]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        ack_d   = ack_q;
        ready_d = '0;
        we_d    = 1'b0;
        grant_d = grant;
        busy_d  = busy;
        err_d   = err;
        din_d   = tx_din;
`ifdef LINE_LOCK_EN
        lock_d  = lock_q;
        lidx_d  = lidx_q;
        lcnt_d  = lcnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef LINE_LOCK_EN
                if (lock_q && !req_valid[lidx_q]) begin
                    if (lcnt_q == LW'(LOCK_TIMEOUT - 1)) begin
                        lock_d = 1'b0;
                        lcnt_d = '0;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end else begin
                    lcnt_d = '0;
                end
`endif
                if (tx_empty && found) begin
                    din_d   = req_data[8*int'(sel) +: 8];
                    we_d    = 1'b1;
                    ready_d = ONE << sel;
                    grant_d = ONE << sel;
                    busy_d  = 1'b1;
                    rr_d    = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
                    ack_d   = '0;
                    state_d = ISSUE;
`ifdef LINE_LOCK_EN
                    lock_d  = (din_d != 8'h0A);
                    lidx_d  = sel;
                    lcnt_d  = '0;
`endif
                end
            end
            ISSUE: begin
                if (!tx_empty) begin
                    state_d = BUSY;
                end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
                    // Serializer never took the byte; drop it and flag.
                    err_d   = 1'b1;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            BUSY: begin
                if (tx_empty) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            ack_q     <= '0;
            req_ready <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            tx_we     <= 1'b0;
            tx_din    <= 8'h00;
`ifdef LINE_LOCK_EN
            lock_q    <= 1'b0;
            lidx_q    <= '0;
            lcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            ack_q     <= ack_d;
            req_ready <= ready_d;
            grant     <= grant_d;
            busy      <= busy_d;
            err       <= err_d;
            tx_we     <= we_d;
            tx_din    <= din_d;
`ifdef LINE_LOCK_EN
            lock_q    <= lock_d;
            lidx_q    <= lidx_d;
            lcnt_q    <= lcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a counting serializer stub.
// Line-lock expectations follow LINE_LOCK_EN.
module tb_uart_tx_arbiter;

    localparam int FRAME = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        busy, err, tx_we;
    logic [7:0]  tx_din;
    logic        tx_empty;

    logic hold_busy = 1'b0;
    logic stuck     = 1'b0;
    int   ser_cnt   = 0;
    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] log_din[$];
    logic [1:0] log_rdy[$];
    int         log_t[$];

    uart_tx_arbiter #(.NUM_REQ(2), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant(grant),
        .busy(busy), .err(err),
        .tx_we(tx_we), .tx_din(tx_din),
        .tx_empty(tx_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer stub: empty drops the cycle after a strobe, for FRAME cycles.
    always @(posedge clk) begin
        if (rst) ser_cnt <= 0;
        else if (tx_we && !stuck) ser_cnt <= FRAME;
        else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
    end
    assign tx_empty = (ser_cnt == 0) && !hold_busy;

    always @(negedge clk) begin
        if (tx_we) begin
            log_din.push_back(tx_din);
            log_rdy.push_back(req_ready);
            log_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_din.delete();
        log_rdy.delete();
        log_t.delete();
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300 && busy; c++) @(negedge clk);
        check("idle_wait", {31'd0, busy}, 0);
    endtask

    task automatic run_streams(input int max_cyc, input int want);
        logic [1:0] pop;
        pop = '0;
        for (int c = 0; c < max_cyc && log_din.size() < want; c++) begin
            @(negedge clk);
            if (pop[0]) void'(q0.pop_front());
            if (pop[1]) void'(q1.pop_front());
            req_valid = {q1.size() != 0, q0.size() != 0};
            req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
            req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
            pop = req_ready & req_valid;
        end
        req_valid = '0;
        q0.delete();
        q1.delete();
    endtask

    function automatic logic [31:0] at_din(input int i);
        return (i < log_din.size()) ? {24'd0, log_din[i]} : 32'hFFFF;
    endfunction

    logic [7:0] exp_ll[4];

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {req_ready, grant, busy, err, tx_we, tx_din}, 0);
        rst = 1'b0;

        // Single byte
        req_data = 16'h0055;
        req_valid = 2'b01;
        @(negedge clk);
        check("sb_we", {31'd0, tx_we}, 1);
        check("sb_ready", {30'd0, req_ready}, 2'b01);
        check("sb_grant", {30'd0, grant}, 2'b01);
        check("sb_din", {24'd0, tx_din}, 8'h55);
        @(negedge clk);
        req_valid = '0;
        check("sb_pulse", {req_ready, tx_we}, 0);
        repeat (10) @(negedge clk);
        check("sb_busy", {31'd0, busy}, 1);
        wait_idle();
        check("sb_frames", log_din.size(), 1);
        check("sb_din_hold", {24'd0, tx_din}, 8'h55);

        // Contention
        do_reset();
        repeat (4) begin q0.push_back(8'hA1); q1.push_back(8'hB2); end
        run_streams(600, 4);
        wait_idle();
        check("ct_count", log_din.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ct_din%0d", i), at_din(i), (i % 2) ? 8'hB2 : 8'hA1);
            if (i < log_rdy.size())
                check($sformatf("ct_rdy%0d", i), {30'd0, log_rdy[i]},
                      (i % 2) ? 2'b10 : 2'b01);
            if (i > 0 && i < log_t.size())
                check($sformatf("ct_gap%0d", i),
                      {31'd0, (log_t[i] - log_t[i-1]) > FRAME}, 1);
        end

        // Back-pressure
        log_din.delete();
        hold_busy = 1'b1;
        req_data = 16'hC300;
        req_valid = 2'b10;
        repeat (20) @(negedge clk);
        check("bp_no_we", log_din.size(), 0);
        hold_busy = 1'b0;
        @(negedge clk);
        check("bp_we", {31'd0, tx_we}, 1);
        check("bp_ready", {30'd0, req_ready}, 2'b10);
        @(negedge clk);
        req_valid = '0;
        wait_idle();

        // Ack timeout
        stuck = 1'b1;
        req_data = 16'h0077;
        req_valid = 2'b01;
        @(negedge clk);
        check("to_we", {31'd0, tx_we}, 1);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("to_early", {31'd0, err}, 0);
        @(negedge clk);
        check("to_err", {31'd0, err}, 1);
        check("to_clear", {grant, busy}, 0);
        stuck = 1'b0;
        req_data = 16'h8800;
        req_valid = 2'b10;
        @(negedge clk);
        check("to_next_we", {31'd0, tx_we}, 1);
        check("to_next_rdy", {30'd0, req_ready}, 2'b10);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
        check("to_sticky", {31'd0, err}, 1);

        // Reset mid-byte
        do_reset();
        check("rb_err_clr", {31'd0, err}, 0);
        req_data = 16'h003C;
        req_valid = 2'b01;
        repeat (2) @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        check("rb_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rb_outs", {req_ready, grant, busy, err, tx_we, tx_din}, 0);
        rst = 1'b0;
        req_data = 16'h5A00;
        req_valid = 2'b10;
        @(negedge clk);
        check("rb_we", {31'd0, tx_we}, 1);
        check("rb_grant", {30'd0, grant}, 2'b10);
        check("rb_din", {24'd0, tx_din}, 8'h5A);
        @(negedge clk);
        req_valid = '0;
        wait_idle();

        // Line lock
        do_reset();
        q0.push_back(8'h68); q0.push_back(8'h69); q0.push_back(8'h0A);
        repeat (8) q1.push_back(8'h31);
`ifdef LINE_LOCK_EN
        exp_ll[0] = 8'h68; exp_ll[1] = 8'h69; exp_ll[2] = 8'h0A; exp_ll[3] = 8'h31;
`else
        exp_ll[0] = 8'h68; exp_ll[1] = 8'h31; exp_ll[2] = 8'h69; exp_ll[3] = 8'h31;
`endif
        run_streams(600, 4);
        wait_idle();
        for (int i = 0; i < 4; i++)
            check($sformatf("ll_din%0d", i), at_din(i), {24'd0, exp_ll[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
